// File: rtl/pm_loader.sv
// Boot-time loader: streams instruction words into program memory from address 0,
// optionally reads the image back and checks it (enable with `define PM_LOADER_VERIFY_EN).
`timescale 1ns/1ps
module pm_loader #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 68
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_inst,
    input  logic                       in_last,
    output logic [$clog2(DEPTH)-1:0]   address,
    output logic                       PM_wr,
    output logic                       PM_rd,
    output logic [WIDTH-1:0]           input_inst,
    input  logic [WIDTH-1:0]           inst,
    output logic                       busy,
    output logic                       load_done,
    output logic [$clog2(DEPTH):0]     load_count,
    output logic                       load_error,
    output logic [2:0]                 fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready is high exactly while in LOAD and never depends on in_valid.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic             accept;
    logic             start;
    logic             final_beat;
    logic             cmp_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_addr_q;
    logic             pm_wr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic [CW-1:0]    count_q;

    assign accept     = (state_q == S_LOAD) && in_valid;
    assign start      = ((state_q == S_IDLE) || (state_q == S_DONE)) && load_start;
    assign final_beat = in_last || (count_q == CW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        load_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (accept && final_beat) state_d = S_FLUSH;
            end
`ifdef PM_LOADER_VERIFY_EN
            S_FLUSH:  state_d = S_VERIFY;
            S_VERIFY: if (cmp_q) state_d = S_DONE;
`else
            S_FLUSH:  state_d = S_DONE;
            S_VERIFY: state_d = S_DONE;
`endif
            S_DONE: begin
                busy      = 1'b0;
                load_done = 1'b1;
                if (load_start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write stage: the accepted word is presented to memory one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            wr_addr_q <= '0;
            pm_wr_q   <= 1'b0;
            wr_data_q <= '0;
            count_q   <= '0;
        end else begin
            pm_wr_q <= 1'b0;
            if (start) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else if (accept) begin
                pm_wr_q   <= 1'b1;
                wr_addr_q <= wr_ptr_q;
                wr_data_q <= in_inst;
                count_q   <= count_q + CW'(1);
                if (wr_ptr_q != AW'(DEPTH - 1)) wr_ptr_q <= wr_ptr_q + AW'(1);
            end
        end
    end

`ifdef PM_LOADER_VERIFY_EN
    logic [WIDTH-1:0] checksum_q;
    logic [WIDTH-1:0] readback_q;
    logic [AW-1:0]    rd_addr_q;
    logic             pm_rd_q;
    logic             rd_last_q;
    logic             rd_v1_q;
    logic             rd_last1_q;
    logic             error_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            checksum_q <= '0;
            readback_q <= '0;
            rd_addr_q  <= '0;
            pm_rd_q    <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_v1_q    <= 1'b0;
            rd_last1_q <= 1'b0;
            cmp_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (accept) checksum_q <= checksum_q ^ in_inst;

            // Reads start after FLUSH so the last write has already landed.
            if (state_q == S_FLUSH) begin
                pm_rd_q   <= 1'b1;
                rd_addr_q <= '0;
                rd_last_q <= (count_q == CW'(1));
            end else if (pm_rd_q && !rd_last_q) begin
                rd_addr_q <= rd_addr_q + AW'(1);
                rd_last_q <= ({1'b0, rd_addr_q} + CW'(2)) == count_q;
            end else begin
                pm_rd_q   <= 1'b0;
                rd_last_q <= 1'b0;
            end

            rd_v1_q    <= pm_rd_q;
            rd_last1_q <= pm_rd_q && rd_last_q;
            cmp_q      <= rd_v1_q && rd_last1_q;
            if (rd_v1_q) readback_q <= readback_q ^ inst;

            if ((state_q == S_VERIFY) && cmp_q) error_q <= (readback_q != checksum_q);
        end
    end

    assign PM_rd      = pm_rd_q;
    assign address    = pm_rd_q ? rd_addr_q : wr_addr_q;
    assign load_error = error_q;
`else
    logic unused_inst;
    assign unused_inst = ^inst;
    assign cmp_q       = 1'b0;
    assign PM_rd       = 1'b0;
    assign address     = wr_addr_q;
    assign load_error  = 1'b0;
`endif

    assign PM_wr      = pm_wr_q;
    assign input_inst = wr_data_q;
    assign load_count = count_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_pm_loader.sv
// Scoreboard bench for pm_loader: directed loads, write/read order and timing checks.
`timescale 1ns/1ps
module tb_pm_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [67:0] in_inst = '0;
    logic        in_last = 1'b0;
    logic [4:0]  address;
    logic        PM_wr;
    logic        PM_rd;
    logic [67:0] input_inst;
    logic [67:0] inst = '0;
    logic        busy;
    logic        load_done;
    logic [5:0]  load_count;
    logic        load_error;
    logic [2:0]  fsm_state;

`ifdef PM_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    pm_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_inst(in_inst), .in_last(in_last),
        .address(address), .PM_wr(PM_wr), .PM_rd(PM_rd), .input_inst(input_inst),
        .inst(inst), .busy(busy), .load_done(load_done), .load_count(load_count),
        .load_error(load_error), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_seen = 0;
    logic [4:0]  exp_addr = '0;
    logic [67:0] mem [32];
    logic [67:0] flip67 = 68'b1 << 67;
    bit          corrupt = 1'b0;
    logic [88:0] exp_q [$];   // {cycle[15:0], addr[4:0], data[67:0]}
    logic [4:0]  rd_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: synchronous write, read data valid the cycle after PM_rd.
    always @(posedge clk) begin
        if (PM_wr) mem[address] <= (corrupt && address == 5'd2) ? (input_inst ^ flip67) : input_inst;
        if (PM_rd) inst <= mem[address];
    end

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the expected write/read whenever the DUT strobes memory.
    always @(negedge clk) begin
        logic [88:0] e;
        logic [4:0]  ra;
        if (PM_wr || PM_rd) check("wr_rd_exclusive", 68'(PM_wr & PM_rd), 68'd0);
        if (PM_wr) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual_addr=%0d required=none", address);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", 68'(cyc), 68'(e[88:73]));
                check("wr_addr", 68'(address), 68'(e[72:68]));
                check("wr_data", input_inst, e[67:0]);
            end
        end
        if (PM_rd) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read actual_addr=%0d required=none", address);
            end else begin
                ra = rd_q.pop_front();
                check("rd_addr", 68'(address), 68'(ra));
            end
        end
    end

    task automatic beat(input logic v, input logic [67:0] w, input logic l);
        @(negedge clk);
        in_valid = v; in_inst = w; in_last = l;
        if (v && in_ready) begin
            exp_q.push_back({16'(cyc + 1), exp_addr, w});
            exp_addr++;
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        in_valid = 1'b0; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("in_ready_after_start", 68'(in_ready), 68'd1);
        check("done_clear_after_start", 68'(load_done), 68'd0);
        exp_addr = '0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            k++;
        end while (!load_done && k < 200);
    endtask

    task automatic finish_load(input int n);
        int k;
        if (VER) for (int i = 0; i < n; i++) rd_q.push_back(5'(i));
        wait_done(k);
        check("done_latency", 68'(k), VER ? 68'(n + 4) : 68'd2);
        check("busy_in_done", 68'(busy), 68'd0);
    endtask

    initial begin
        int k;
        int base;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 68'(in_ready), 68'd0);
        check("rst_address", 68'(address), 68'd0);
        check("rst_pm_wr", 68'(PM_wr), 68'd0);
        check("rst_pm_rd", 68'(PM_rd), 68'd0);
        check("rst_input_inst", input_inst, 68'd0);
        check("rst_busy", 68'(busy), 68'd0);
        check("rst_load_done", 68'(load_done), 68'd0);
        check("rst_load_count", 68'(load_count), 68'd0);
        check("rst_load_error", 68'(load_error), 68'd0);
        rst = 1'b0;

        // Four back-to-back words, last on 0xD.
        start_load();
        beat(1'b1, 68'hA, 1'b0);
        beat(1'b1, 68'hB, 1'b0);
        beat(1'b1, 68'hC, 1'b0);
        beat(1'b1, 68'hD, 1'b1);
        finish_load(4);
        check("abcd_count", 68'(load_count), 68'd4);
        check("abcd_error", 68'(load_error), 68'd0);

        // 40 words offered, in_last never set: only 32 may be written.
        start_load();
        base = wr_seen;
        if (VER) for (int i = 0; i < 32; i++) rd_q.push_back(5'(i));
        for (int i = 0; i < 40; i++) begin
            beat(1'b1, {4'h5, 64'(i * 32'h0101_0101)}, 1'b0);
            if (i == 32) check("in_ready_after_32", 68'(in_ready), 68'd0);
        end
        wait_done(k);
        check("full_done", 68'(load_done), 68'd1);
        check("full_writes", 68'(wr_seen - base), 68'd32);
        check("full_count", 68'(load_count), 68'd32);

        // in_valid gaps 1,0,0,1,1 give matching PM_wr gaps.
        start_load();
        beat(1'b1, 68'h1_1111, 1'b0);
        beat(1'b0, 68'h0, 1'b0);
        beat(1'b0, 68'h0, 1'b0);
        beat(1'b1, 68'h2_2222, 1'b0);
        beat(1'b1, 68'h3_3333, 1'b1);
        finish_load(3);
        check("gap_count", 68'(load_count), 68'd3);

        // load_start during LOAD is ignored.
        start_load();
        beat(1'b1, 68'hF_0000_0000_0000_0001, 1'b0);
        beat(1'b1, 68'hF_0000_0000_0000_0002, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("mid_start_count", 68'(load_count), 68'd2);
        check("mid_start_in_ready", 68'(in_ready), 68'd1);
        beat(1'b1, 68'hF_0000_0000_0000_0003, 1'b0);
        beat(1'b1, 68'hF_0000_0000_0000_0004, 1'b1);
        finish_load(4);
        check("mid_start_final_count", 68'(load_count), 68'd4);

        // load_start in DONE restarts from address 0.
        start_load();
        beat(1'b1, 68'h7_7777, 1'b1);
        finish_load(1);
        check("restart_count", 68'(load_count), 68'd1);

        // Reset during the third beat.
        start_load();
        beat(1'b1, 68'h9_0001, 1'b0);
        beat(1'b1, 68'h9_0002, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_inst = 68'h9_0003; rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 68'(in_ready), 68'd0);
        check("mid_rst_address", 68'(address), 68'd0);
        check("mid_rst_pm_wr", 68'(PM_wr), 68'd0);
        check("mid_rst_pm_rd", 68'(PM_rd), 68'd0);
        check("mid_rst_input_inst", input_inst, 68'd0);
        check("mid_rst_busy", 68'(busy), 68'd0);
        check("mid_rst_done", 68'(load_done), 68'd0);
        check("mid_rst_count", 68'(load_count), 68'd0);
        rst = 1'b0; in_valid = 1'b0;
        start_load();
        beat(1'b1, 68'h8_8888, 1'b1);
        finish_load(1);
        check("post_rst_count", 68'(load_count), 68'd1);

`ifdef PM_LOADER_VERIFY_EN
        // Corrupted readback of word 2 must raise load_error.
        corrupt = 1'b1;
        start_load();
        beat(1'b1, 68'hA, 1'b0);
        beat(1'b1, 68'hB, 1'b0);
        beat(1'b1, 68'hC, 1'b0);
        beat(1'b1, 68'hD, 1'b1);
        finish_load(4);
        check("corrupt_error", 68'(load_error), 68'd1);
        corrupt = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("wr_queue_empty", 68'(exp_q.size()), 68'd0);
        check("rd_queue_empty", 68'(rd_q.size()), 68'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/pm_loader.md
# pm_loader

Boot-time writer for the 32 x 68-bit program memory. Accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive addresses from 0 using the memory's write port. It then optionally reads the image back and checks it, and signals completion so the fetch stage can take over the memory's read port. The block sits between the host/test loader and program memory and owns PM_wr during load.

## Interface
Parameters:
- DEPTH, 32, number of program memory words; address width is 5.
- WIDTH, 68, instruction word width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; synchronous and active-high.
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  in  1  in_inst/in_last valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_inst  in  68  instruction word.
- in_last  in  1  marks final word of the image.
- address  out  5  program memory address.
- PM_wr  out  1  memory write strobe.
- PM_rd  out  1  memory read strobe.
- input_inst  out  68  memory write data.
- inst  in  68  memory read data; valid the cycle after PM_rd.
- busy  out  1  high in any state other than IDLE/DONE.
- load_done  out  1  level; image loaded (and checked, if enabled).
- load_count  out  6  words written, 1..32; held in DONE.
- load_error  out  1  readback checksum mismatch; always 0 without verify.

## Operation
- States: IDLE, LOAD, FLUSH, VERIFY (verify builds only), DONE.
- IDLE: in_ready=0, PM_wr=0, PM_rd=0. load_start -> LOAD; wr_ptr, load_count, checksum, load_done and load_error cleared.
- LOAD: in_ready=1. Beat accepted when in_valid && in_ready.
  - Next cycle: PM_wr=1, address=wr_ptr, input_inst=accepted word.
  - wr_ptr and load_count increment; checksum ^= word.
  - Back-to-back beats give one write per cycle. in_valid gaps produce PM_wr=0 cycles.
- Termination: an accepted beat with in_last=1, or the 32nd accepted beat regardless of in_last, moves to FLUSH. in_ready drops in the cycle after that beat. Words beyond 32 are never accepted.
- FLUSH: the final PM_wr cycle.
  - Without verify: next state DONE.
  - With verify: next state VERIFY.
- PM_wr and PM_rd are never high in the same cycle. Both are 0 in IDLE and DONE.
- DONE: load_done=1, busy=0. load_start restarts the load as from IDLE.
- load_start in LOAD, FLUSH or VERIFY is ignored.
- Reset mid-operation: returns to IDLE on the next edge with all outputs at reset values. Partially written memory content is not defined.

## Timing
- Reset values: in_ready=0, address=0, PM_wr=0, PM_rd=0, input_inst=0, busy=0, load_done=0, load_count=0, load_error=0.
- load_start at edge N: LOAD from edge N+1, in_ready=1 in cycle N+1.
- Beat accepted at edge K: PM_wr=1 during cycle K+1. The memory captures the word at edge K+2.
- Without verify: last beat at edge L -> PM_wr cycle L+1 -> load_done=1 from cycle L+2.
- VERIFY read pipeline:
  - PM_rd=1 with address 0..load_count-1 on consecutive cycles, starting the cycle after FLUSH.
  - The first read follows the last write edge, so it sees updated content.
  - Each inst is XOR-folded one cycle after its read.
  - One cycle after the final fold: DONE, load_done=1, and load_error=1 if the readback XOR != load checksum.
  - Verify latency is load_count+2 cycles.
- address wraps are impossible: at most 32 writes, and the 5-bit pointer stops at 31.

## Configuration
- PM_LOADER_VERIFY_EN defined: VERIFY state, readback pipeline, 68-bit checksums and load_error logic are compiled in.
- Not defined: FLUSH goes straight to DONE, PM_rd is tied 0, inst is unused, and load_error is tied 0.

## Test plan
- Words 0xA, 0xB, 0xC, 0xD streamed, in_last on 0xD -> PM_wr on 4 consecutive cycles, addresses 0..3 with those data, load_count=4, load_done=1 two cycles after the last beat.
- 40 words with in_last never set -> exactly 32 writes at addresses 0..31, in_ready low after the 32nd beat, load_count=32.
- in_valid toggling 1,0,0,1,1 (last on the final beat) -> 3 writes with PM_wr gaps matching the input gaps, addresses 0,1,2.
- Verify build, 4-word image, memory model unmodified -> PM_rd on addresses 0..3, load_error=0, load_done=1. Same load with the bench flipping bit 67 of word 2 before readback -> load_error=1.
- rst asserted during the 3rd beat -> all outputs at reset values next cycle. A new load_start then writes from address 0 with load_count restarting at 1.
- load_start pulsed mid-LOAD -> no effect on wr_ptr/load_count. load_start in DONE -> load_done cleared next cycle and a new load begins at address 0.
